// File: rtl/mbist_pkg.sv
// Shared types and constants for the MBIST memory scheduler.
package mbist_pkg;

  localparam int MEM_SEL_WIDTH         = 3;
  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int DEFAULT_WDOG_WIDTH    = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_RECORD,
    ST_RELEASE,
    ST_DONE
  } sched_state_e;

endpackage

// File: rtl/mbist_next_mem.sv
// Priority finder: lowest enabled memory index strictly above cur_idx,
// or the lowest enabled index overall when from_start is set.
module mbist_next_mem
  import mbist_pkg::*;
#(
  parameter int NUM_MEM = 4
) (
  input  logic [NUM_MEM-1:0]       mask,
  input  logic [MEM_SEL_WIDTH-1:0] cur_idx,
  input  logic                     from_start,
  output logic [MEM_SEL_WIDTH-1:0] next_idx,
  output logic                     found
);

  logic [NUM_MEM-1:0] cand;

  for (genvar gi = 0; gi < NUM_MEM; gi++) begin : g_cand
    assign cand[gi] = mask[gi] && (from_start || (MEM_SEL_WIDTH'(gi) > cur_idx));
  end

  // Scan downwards so the lowest candidate is the one that sticks.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_MEM - 1; i >= 0; i--) begin
      if (cand[i]) begin
        next_idx = MEM_SEL_WIDTH'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mbist_mem_scheduler.sv
// Walks the enabled memories one at a time: select, settle, run the
// controller, record pass/fail/timeout, wait for complete to drop, next.
module mbist_mem_scheduler
  import mbist_pkg::*;
#(
  parameter int NUM_MEM       = 4,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int WDOG_WIDTH    = DEFAULT_WDOG_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [NUM_MEM-1:0]       mem_enable_mask,
  input  logic [2:0]               operation_cfg,
  input  logic                     test_complete,
  input  logic                     test_error,
  input  logic                     test_force_terminate,
  output logic [MEM_SEL_WIDTH-1:0] memory_sel,
  output logic                     test_mode,
  output logic [2:0]               operation,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_MEM-1:0]       pass_vector,
  output logic [NUM_MEM-1:0]       fail_vector,
  output logic [NUM_MEM-1:0]       timeout_vector,
  output logic                     aborted
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  sched_state_e             state_reg, state_next;
  logic [NUM_MEM-1:0]       mask_reg, mask_next;
  logic [2:0]               op_reg, op_next;
  logic [MEM_SEL_WIDTH-1:0] sel_reg, sel_next;
  logic [7:0]               settle_cnt_reg, settle_cnt_next;
  logic [WDOG_WIDTH-1:0]    wdog_reg, wdog_next;
  logic                     err_reg, err_next;
  logic [NUM_MEM-1:0]       pass_reg, pass_next;
  logic [NUM_MEM-1:0]       fail_reg, fail_next;
  logic [NUM_MEM-1:0]       tmo_reg, tmo_next;
  logic                     aborted_reg, aborted_next;

  logic                     idle_or_done;
  logic [NUM_MEM-1:0]       find_mask;
  logic [MEM_SEL_WIDTH-1:0] nxt_idx;
  logic                     nxt_found;
  logic [NUM_MEM-1:0]       sel_onehot;
  logic [WDOG_WIDTH-1:0]    wdog_inc;
  logic                     wdog_hit;

  assign idle_or_done = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
  // One finder serves both the first pick (live mask) and the walk (latched mask).
  assign find_mask    = idle_or_done ? mem_enable_mask : mask_reg;
  assign sel_onehot   = NUM_MEM'(1) << sel_reg;
  assign wdog_inc     = wdog_reg + WDOG_WIDTH'(1);
  assign wdog_hit     = &wdog_inc;

  mbist_next_mem #(
    .NUM_MEM (NUM_MEM)
  ) u_next_mem (
    .mask       (find_mask),
    .cur_idx    (sel_reg),
    .from_start (idle_or_done),
    .next_idx   (nxt_idx),
    .found      (nxt_found)
  );

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    op_next         = op_reg;
    sel_next        = sel_reg;
    settle_cnt_next = settle_cnt_reg;
    wdog_next       = wdog_reg;
    err_next        = err_reg;
    pass_next       = pass_reg;
    fail_next       = fail_reg;
    tmo_next        = tmo_reg;
    aborted_next    = aborted_reg;

    if (abort && !idle_or_done) begin
      aborted_next = 1'b1;
      state_next   = ST_DONE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mask_next    = mem_enable_mask;
            op_next      = operation_cfg;
            pass_next    = '0;
            fail_next    = '0;
            tmo_next     = '0;
            aborted_next = 1'b0;
            err_next     = 1'b0;
            wdog_next    = '0;
            if (nxt_found) begin
              sel_next        = nxt_idx;
              settle_cnt_next = '0;
              state_next      = ST_SETTLE;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) begin
            state_next = ST_RUN;
          end else begin
            settle_cnt_next = settle_cnt_reg + 8'd1;
          end
        end
        ST_RUN: begin
          wdog_next = wdog_inc;
          if (test_error) begin
            err_next = 1'b1;
          end
          // err_reg doubles as the "record a fail" flag for forced and timed-out exits.
          if (test_force_terminate) begin
            err_next   = 1'b1;
            state_next = ST_RECORD;
          end else if (test_complete) begin
            state_next = ST_RECORD;
          end else if (wdog_hit) begin
            err_next   = 1'b1;
            tmo_next   = tmo_reg | sel_onehot;
            state_next = ST_RECORD;
          end
        end
        ST_RECORD: begin
          if (err_reg) begin
            fail_next = fail_reg | sel_onehot;
          end else begin
            pass_next = pass_reg | sel_onehot;
          end
          err_next   = 1'b0;
          wdog_next  = '0;
          state_next = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!test_complete) begin
            if (nxt_found) begin
              sel_next        = nxt_idx;
              settle_cnt_next = '0;
              state_next      = ST_SETTLE;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      mask_reg       <= '0;
      op_reg         <= '0;
      sel_reg        <= '0;
      settle_cnt_reg <= '0;
      wdog_reg       <= '0;
      err_reg        <= 1'b0;
      pass_reg       <= '0;
      fail_reg       <= '0;
      tmo_reg        <= '0;
      aborted_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      op_reg         <= op_next;
      sel_reg        <= sel_next;
      settle_cnt_reg <= settle_cnt_next;
      wdog_reg       <= wdog_next;
      err_reg        <= err_next;
      pass_reg       <= pass_next;
      fail_reg       <= fail_next;
      tmo_reg        <= tmo_next;
      aborted_reg    <= aborted_next;
    end
  end

  assign memory_sel     = sel_reg;
  assign test_mode      = (state_reg == ST_RUN);
  assign operation      = op_reg;
  assign busy           = !idle_or_done;
  assign done           = (state_reg == ST_DONE);
  assign pass_vector    = pass_reg;
  assign fail_vector    = fail_reg;
  assign timeout_vector = tmo_reg;
  assign aborted        = aborted_reg;

endmodule

// File: tb/tb_mbist_mem_scheduler.sv
// Self-checking bench for mbist_mem_scheduler: table vectors, randomized
// sessions against a per-memory outcome model, and hand-written corner cases.
module tb_mbist_mem_scheduler;

  localparam int NM  = 4;
  localparam int SC  = 4;
  localparam int WW  = 8;
  localparam int WDOG_RUN_CYCLES = (1 << WW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NM-1:0] mem_enable_mask = '0;
  logic [2:0]    operation_cfg = '0;
  logic          test_complete = 1'b0;
  logic          test_error = 1'b0;
  logic          test_force_terminate = 1'b0;
  logic [2:0]    memory_sel;
  logic          test_mode;
  logic [2:0]    operation;
  logic          busy;
  logic          done;
  logic [NM-1:0] pass_vector;
  logic [NM-1:0] fail_vector;
  logic [NM-1:0] timeout_vector;
  logic          aborted;

  int n_cmp = 0;
  int n_bad = 0;

  mbist_mem_scheduler #(
    .NUM_MEM       (NM),
    .SETTLE_CYCLES (SC),
    .WDOG_WIDTH    (WW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .abort                (abort),
    .mem_enable_mask      (mem_enable_mask),
    .operation_cfg        (operation_cfg),
    .test_complete        (test_complete),
    .test_error           (test_error),
    .test_force_terminate (test_force_terminate),
    .memory_sel           (memory_sel),
    .test_mode            (test_mode),
    .operation            (operation),
    .busy                 (busy),
    .done                 (done),
    .pass_vector          (pass_vector),
    .fail_vector          (fail_vector),
    .timeout_vector       (timeout_vector),
    .aborted              (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NM-1:0] mask;
    logic [2:0]    op;
    int            lat;
    int            hold;
    int            err_mem;
    int            ft_mem;
    int            nc_mem;
    logic [NM-1:0] exp_pass;
    logic [NM-1:0] exp_fail;
    logic [NM-1:0] exp_tmo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tm(input logic lvl, input string nm);
    for (int n = 0; n < 2000 && test_mode !== lvl; n++) tick();
    chk(nm, 32'(test_mode), 32'(lvl));
  endtask

  task automatic wait_done(input string nm);
    for (int n = 0; n < 2000 && done !== 1'b1; n++) tick();
    chk(nm, 32'(done), 32'd1);
  endtask

  // Acts as the controller for one whole session and checks order, settle
  // timing, select stability, watchdog length and the final result vectors.
  task automatic run_session(input vec_t v, input string tag);
    int q[$];
    int cyc, sel_edge, run_cnt, hold_cnt, cur_mem, exp_mem;
    logic tm_prev;
    logic [2:0] sel_prev;
    bit sel_moved;
    for (int i = 0; i < NM; i++) if (v.mask[i]) q.push_back(i);
    test_complete = 1'b0; test_error = 1'b0; test_force_terminate = 1'b0;
    mem_enable_mask = v.mask;
    operation_cfg = v.op;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; sel_edge = 0; run_cnt = 0; hold_cnt = 0; cur_mem = -1;
    tm_prev = 1'b0; sel_prev = memory_sel; sel_moved = 1'b0;
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 3000) begin
      if (memory_sel != sel_prev) begin
        sel_edge = cyc;
        if (test_mode && tm_prev) sel_moved = 1'b1;
      end
      if (test_mode && !tm_prev) begin
        chk({tag, "_settle"}, 32'(cyc - sel_edge), 32'(SC));
        exp_mem = (q.size() > 0) ? q.pop_front() : -1;
        chk({tag, "_order"}, 32'(memory_sel), 32'(exp_mem));
        cur_mem = int'(memory_sel);
        run_cnt = 0; hold_cnt = 0;
      end
      if (!test_mode && tm_prev && cur_mem == v.nc_mem)
        chk({tag, "_wdog_cycles"}, 32'(run_cnt), 32'(WDOG_RUN_CYCLES));
      if (test_mode) begin
        run_cnt++;
        test_error = (cur_mem == v.err_mem) && (run_cnt == 1);
        if (cur_mem != v.nc_mem && run_cnt == v.lat) begin
          if (cur_mem == v.ft_mem) test_force_terminate = 1'b1;
          else test_complete = 1'b1;
        end
      end else begin
        test_error = 1'b0;
        test_force_terminate = 1'b0;
        if (test_complete) begin
          if (hold_cnt >= v.hold) test_complete = 1'b0;
          else hold_cnt++;
        end
      end
      tm_prev = test_mode;
      sel_prev = memory_sel;
      tick();
      cyc++;
    end
    test_complete = 1'b0; test_error = 1'b0; test_force_terminate = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_all_tested"}, 32'(q.size()), 32'd0);
    chk({tag, "_sel_stable"}, 32'(sel_moved), 32'd0);
    chk({tag, "_pass"}, 32'(pass_vector), 32'(v.exp_pass));
    chk({tag, "_fail"}, 32'(fail_vector), 32'(v.exp_fail));
    chk({tag, "_timeout"}, 32'(timeout_vector), 32'(v.exp_tmo));
    chk({tag, "_disjoint"}, 32'(pass_vector & fail_vector), 32'd0);
    chk({tag, "_operation"}, 32'(operation), 32'(v.op));
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    $display("session %-10s mask=%b op=%0d pass=%b fail=%b tmo=%b cycles=%0d",
             tag, v.mask, v.op, pass_vector, fail_vector, timeout_vector, cyc);
  endtask

  initial begin
    vec_t v;
    bit tm_seen;

    tbl[0] = '{4'b1011, 3'd1, 100, 0, -1, -1, -1, 4'b1011, 4'b0000, 4'b0000};
    tbl[1] = '{4'b1111, 3'd2, 20, 1, 2, -1, -1, 4'b1011, 4'b0100, 4'b0000};
    tbl[2] = '{4'b0001, 3'd3, 10, 0, -1, -1, 0, 4'b0000, 4'b0001, 4'b0001};
    tbl[3] = '{4'b0110, 3'd4, 5, 2, -1, 1, -1, 4'b0100, 4'b0010, 4'b0000};
    tbl[4] = '{4'b1000, 3'd5, 3, 3, -1, -1, -1, 4'b1000, 4'b0000, 4'b0000};
    tbl[5] = '{4'b0101, 3'd6, 7, 0, 0, 2, -1, 4'b0000, 4'b0101, 4'b0000};

    #17;
    chk("rst_memory_sel", 32'(memory_sel), 32'd0);
    chk("rst_test_mode", 32'(test_mode), 32'd0);
    chk("rst_operation", 32'(operation), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_vector), 32'd0);
    chk("rst_fail", 32'(fail_vector), 32'd0);
    chk("rst_timeout", 32'(timeout_vector), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) run_session(tbl[t], $sformatf("tbl%0d", t));

    // Randomized sessions; expectations come from per-memory outcome rules.
    for (int r = 0; r < 24; r++) begin
      v.mask = NM'($urandom_range(1, 15));
      v.op = 3'($urandom_range(0, 7));
      v.lat = $urandom_range(2, 30);
      v.hold = $urandom_range(0, 3);
      v.err_mem = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NM - 1) : -1;
      v.ft_mem = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NM - 1) : -1;
      v.nc_mem = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NM - 1) : -1;
      v.exp_pass = '0; v.exp_fail = '0; v.exp_tmo = '0;
      for (int i = 0; i < NM; i++) begin
        if (v.mask[i]) begin
          if (i == v.nc_mem) begin
            v.exp_fail[i] = 1'b1;
            v.exp_tmo[i] = 1'b1;
          end else if (i == v.ft_mem || i == v.err_mem) begin
            v.exp_fail[i] = 1'b1;
          end else begin
            v.exp_pass[i] = 1'b1;
          end
        end
      end
      run_session(v, $sformatf("rnd%0d", r));
    end

    // Empty mask: straight to DONE, controller never enabled, old results cleared.
    mem_enable_mask = '0; operation_cfg = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    chk("mask0_done", 32'(done), 32'd1);
    chk("mask0_busy", 32'(busy), 32'd0);
    chk("mask0_pass_cleared", 32'(pass_vector), 32'd0);
    tm_seen = 1'b0;
    for (int n = 0; n < 10; n++) begin tick(); if (test_mode) tm_seen = 1'b1; end
    chk("mask0_no_test_mode", 32'(tm_seen), 32'd0);
    $display("session mask0      done=%b", done);

    // Start while busy is ignored.
    mem_enable_mask = 4'b0001; operation_cfg = 3'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    mem_enable_mask = 4'b1110; operation_cfg = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_op", 32'(operation), 32'd5);
    chk("busy_start_sel", 32'(memory_sel), 32'd0);
    wait_tm(1'b1, "busy_start_tm_rise");
    tick(); tick();
    test_complete = 1'b1;
    wait_tm(1'b0, "busy_start_tm_fall");
    test_complete = 1'b0;
    wait_done("busy_start_done");
    chk("busy_start_pass", 32'(pass_vector), 32'h1);
    $display("session busystart  pass=%b", pass_vector);

    // Abort during RUN of memory 1.
    mem_enable_mask = 4'b0011; operation_cfg = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tm(1'b1, "abort_tm0");
    tick(); tick();
    test_complete = 1'b1;
    wait_tm(1'b0, "abort_tm0_fall");
    test_complete = 1'b0;
    wait_tm(1'b1, "abort_tm1");
    chk("abort_sel1", 32'(memory_sel), 32'd1);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_test_mode", 32'(test_mode), 32'd0);
    chk("abort_aborted", 32'(aborted), 32'd1);
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_pass", 32'(pass_vector), 32'h1);
    chk("abort_fail", 32'(fail_vector), 32'h0);
    $display("session abortrun   pass=%b fail=%b aborted=%b", pass_vector, fail_vector, aborted);

    // Abort while settling: nothing recorded.
    mem_enable_mask = 4'b1100; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_settle_cleared", 32'(aborted), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_settle_aborted", 32'(aborted), 32'd1);
    chk("abort_settle_done", 32'(done), 32'd1);
    chk("abort_settle_results", 32'({pass_vector, fail_vector}), 32'd0);
    $display("session abortsettl aborted=%b", aborted);

    // Reset mid-RUN after one memory has already passed.
    mem_enable_mask = 4'b0101; operation_cfg = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_tm(1'b1, "rst_tm0");
    test_complete = 1'b1;
    wait_tm(1'b0, "rst_tm0_fall");
    test_complete = 1'b0;
    wait_tm(1'b1, "rst_tm2");
    chk("rst_pre_pass", 32'(pass_vector), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_sel", 32'(memory_sel), 32'd0);
    chk("rst_mid_tm", 32'(test_mode), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_pass", 32'(pass_vector), 32'd0);
    chk("rst_mid_op", 32'(operation), 32'd0);
    #10;
    rst_n = 1'b1;
    tick();
    run_session(tbl[0], "postrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
